uart_rx: RTL



---
 rtl/uart_rx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronized line, mid-bit sampling, LSB first,
// one-cycle valid/error pulses, framing-error lockout until the line idles high.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rx_valid_o,
  output logic       rx_err_o
);

  localparam int unsigned CNT_W = 14;
  localparam int unsigned CPB   = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF  = (CPB - 1) / 2;

  localparam logic [CNT_W-1:0] CPB_M1 = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!rx_s_q) state_d = START;
      START:     if (cnt_q == HALF_C) state_d = rx_s_q ? IDLE : DATA;
      DATA:      if (cnt_q == CPB_M1 && bit_idx_q == 3'd7) state_d = STOP;
      STOP:      if (cnt_q == CPB_M1) state_d = rx_s_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath next-state: bit timer, bit index, shift register and output pulses.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        if (cnt_q == HALF_C) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = (bit_idx_q == 3'd7) ? 3'd0 : bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: cnt_d = '0;
      default:   cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data_o     = data_q;
  assign rx_valid_o = valid_q;
  assign rx_err_o   = err_q;

endmodule
